// File: rtl/inst_intensity_gen.sv
// Per-instrument intensity bytes {flag, level[6:0]} fed by a small hit FIFO.
// State freezes on the capture row and decays once per frame just after it.
module inst_intensity_gen #(
  parameter int INSTRUMENT_COUNT = 3,
  parameter int HIT_FIFO_DEPTH   = 4,
  parameter int DECAY_SHIFT      = 3,
  parameter int CAPTURE_V        = 721,
  parameter int IW               = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [10:0]                       h_count,
  input  logic [9:0]                        v_count,
  input  logic                              hit_valid,
  output logic                              hit_ready,
  input  logic [IW-1:0]                     hit_inst,
  input  logic [6:0]                        hit_velocity,
  output logic [INSTRUMENT_COUNT-1:0][7:0]  inst_intensity
);

  localparam int AW = $clog2(HIT_FIFO_DEPTH);
  localparam logic [IW:0] N_W = (IW+1)'(INSTRUMENT_COUNT);

  // Handshake: a hit is taken on any cycle where hit_valid && hit_ready;
  // hit_ready depends only on the registered occupancy, never on this cycle's pop.
  logic [IW-1:0] fifo_inst [HIT_FIFO_DEPTH];
  logic [6:0]    fifo_vel  [HIT_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic          freeze, decay_tick;
  logic [IW-1:0] pop_inst;
  logic [6:0]    pop_vel;
  logic          pop_ok;

  assign full       = (count == (AW+1)'(HIT_FIFO_DEPTH));
  assign empty      = (count == '0);
  assign hit_ready  = !full;
  assign push       = hit_valid && !full;
  assign freeze     = (v_count == 10'(CAPTURE_V));
  assign decay_tick = (v_count == 10'(CAPTURE_V + 1)) && (h_count == 11'd0);
  assign pop        = !empty && !freeze && !decay_tick;

  assign pop_inst = fifo_inst[rd_ptr];
  assign pop_vel  = fifo_vel[rd_ptr];
  // Out-of-range instruments and zero velocity are consumed without effect.
  assign pop_ok   = ({1'b0, pop_inst} < N_W) && (pop_vel != 7'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= hit_inst;
      fifo_vel[wr_ptr]  <= hit_velocity;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < INSTRUMENT_COUNT; i++) begin : g_inst
    logic       flag;
    logic [6:0] level;
    logic [6:0] shifted;
    logic [6:0] sub;
    logic       hit_here;

    assign shifted  = level >> DECAY_SHIFT;
    assign sub      = (shifted == 7'd0) ? 7'd1 : shifted;
    assign hit_here = pop && pop_ok && (pop_inst == IW'(i));

    // decay_tick and pops are mutually exclusive, and neither happens during freeze.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        flag  <= 1'b0;
        level <= 7'd0;
      end else if (decay_tick) begin
        flag  <= 1'b0;
        level <= (level > sub) ? (level - sub) : 7'd0;
      end else if (hit_here) begin
        if (!flag) begin
          flag  <= 1'b1;
          level <= pop_vel;
        end else if (pop_vel > level) begin
          level <= pop_vel;
        end
      end
    end

    assign inst_intensity[i] = {flag, level};
  end

endmodule

// File: tb/tb_inst_intensity_gen.sv
// Self-checking bench for inst_intensity_gen: hit table, decay, freeze
// backpressure, discards and asynchronous reset mid-burst.
module tb_inst_intensity_gen;
  localparam int N = 3;
  localparam logic [9:0] CAP_V = 10'd721;

  logic             clk = 1'b0;
  logic             rst;
  logic [10:0]      h_count;
  logic [9:0]       v_count;
  logic             hit_valid;
  logic             hit_ready;
  logic [1:0]       hit_inst;
  logic [6:0]       hit_velocity;
  logic [N-1:0][7:0] inst_intensity;

  always #5 clk = ~clk;

  inst_intensity_gen #(
    .INSTRUMENT_COUNT(N),
    .HIT_FIFO_DEPTH(4),
    .DECAY_SHIFT(3),
    .CAPTURE_V(721)
  ) dut (
    .clk(clk),
    .rst(rst),
    .h_count(h_count),
    .v_count(v_count),
    .hit_valid(hit_valid),
    .hit_ready(hit_ready),
    .hit_inst(hit_inst),
    .hit_velocity(hit_velocity),
    .inst_intensity(inst_intensity)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [1:0]  inst;
    logic [6:0]  vel;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_ready(input string name, input logic exp);
    check_val(name, {23'd0, hit_ready}, {23'd0, exp});
  endtask

  task automatic expect_out(input logic [23:0] e);
    exp_q.push_back(e);
  endtask

  task automatic compare_out(input string name);
    logic [23:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no expected value queued, got %h", name, inst_intensity);
    end else begin
      e = exp_q.pop_front();
      check_val(name, inst_intensity, e);
    end
  endtask

  task automatic send_hit(input string name, input logic [1:0] inst, input logic [6:0] vel,
                          input logic [23:0] exp);
    hit_inst     = inst;
    hit_velocity = vel;
    hit_valid    = 1'b1;
    expect_out(exp);
    check_ready({name, "_ready"}, 1'b1);
    tick();
    hit_valid = 1'b0;
    tick();
    compare_out(name);
  endtask

  task automatic decay_frame();
    v_count = CAP_V + 10'd1;
    h_count = 11'd0;
    tick();
    h_count = 11'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic [23:0] drain_exp[4];
  logic [6:0]  floor_exp[6];

  initial begin
    rst = 1'b1; h_count = 11'd5; v_count = 10'd10;
    hit_valid = 1'b0; hit_inst = 2'd0; hit_velocity = 7'd0;

    // Reset state
    tick(); tick();
    expect_out(24'h000000);
    compare_out("reset_out");
    rst = 1'b0;
    tick();
    check_ready("reset_ready", 1'b1);

    // Hit table: {inst, velocity, expected {i2,i1,i0}}
    vecs[0] = '{2'd1, 7'd100, 24'h00E400};
    vecs[1] = '{2'd0, 7'd40,  24'h00E4A8};
    vecs[2] = '{2'd0, 7'd90,  24'h00E4DA};
    vecs[3] = '{2'd0, 7'd20,  24'h00E4DA};
    vecs[4] = '{2'd3, 7'd50,  24'h00E4DA};
    vecs[5] = '{2'd2, 7'd0,   24'h00E4DA};
    vecs[6] = '{2'd2, 7'd127, 24'hFFE4DA};
    vecs[7] = '{2'd2, 7'd1,   24'hFFE4DA};
    for (int k = 0; k < 8; k++)
      send_hit($sformatf("hit_vec%0d", k), vecs[k].inst, vecs[k].vel, vecs[k].exp);

    // Capture row holds, then decay: 90->79, 100->88, 127->112, flags clear
    v_count = CAP_V; h_count = 11'd0;
    expect_out(24'hFFE4DA);
    tick();
    compare_out("freeze_hold");
    decay_frame();
    expect_out(24'h70584F);
    compare_out("decay1");

    // Freeze backpressure: 6 offers, only 4 accepted
    v_count = CAP_V;
    for (int k = 0; k < 6; k++) begin
      h_count = 11'(k);
      hit_valid = 1'b1;
      case (k)
        0: begin hit_inst = 2'd0; hit_velocity = 7'd100; end
        1: begin hit_inst = 2'd1; hit_velocity = 7'd10;  end
        2: begin hit_inst = 2'd2; hit_velocity = 7'd5;   end
        3: begin hit_inst = 2'd0; hit_velocity = 7'd120; end
        default: begin hit_inst = 2'd1; hit_velocity = 7'd99; end
      endcase
      check_ready($sformatf("bp_ready%0d", k), (k < 4));
      expect_out(24'h70584F);
      tick();
      compare_out($sformatf("bp_hold%0d", k));
    end
    hit_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_out(24'h70584F);
      tick();
      compare_out($sformatf("bp_idle%0d", k));
    end
    // Decay 79->70, 88->77, 112->98, then queued hits in order
    decay_frame();
    expect_out(24'h624D46);
    compare_out("bp_decay");
    check_ready("bp_ready_full", 1'b0);
    drain_exp[0] = 24'h624DE4;
    drain_exp[1] = 24'h628AE4;
    drain_exp[2] = 24'h858AE4;
    drain_exp[3] = 24'h858AF8;
    for (int k = 0; k < 4; k++) begin
      expect_out(drain_exp[k]);
      tick();
      compare_out($sformatf("bp_drain%0d", k));
      check_ready($sformatf("bp_drain_ready%0d", k), 1'b1);
    end
    expect_out(24'h858AF8);
    tick();
    compare_out("bp_drained");

    // Decay floor from level 5
    rst = 1'b1; tick(); rst = 1'b0;
    v_count = 10'd10; h_count = 11'd5;
    send_hit("floor_load", 2'd1, 7'd5, 24'h008500);
    floor_exp[0] = 7'd4; floor_exp[1] = 7'd3; floor_exp[2] = 7'd2;
    floor_exp[3] = 7'd1; floor_exp[4] = 7'd0; floor_exp[5] = 7'd0;
    for (int f = 0; f < 6; f++) begin
      decay_frame();
      expect_out({8'h00, 1'b0, floor_exp[f], 8'h00});
      compare_out($sformatf("floor%0d", f));
    end

    // Asynchronous reset with three hits queued
    v_count = 10'd10; h_count = 11'd5;
    send_hit("mr_load", 2'd2, 7'd60, 24'hBC0000);
    v_count = CAP_V;
    for (int k = 0; k < 3; k++) begin
      hit_inst = 2'(k); hit_velocity = 7'(10 * (k + 1)); hit_valid = 1'b1;
      tick();
    end
    hit_valid = 1'b0;
    expect_out(24'hBC0000);
    compare_out("mr_before");
    #3 rst = 1'b1;
    #1;
    expect_out(24'h000000);
    compare_out("mr_async_clear");
    @(negedge clk);
    rst = 1'b0;
    v_count = 10'd10;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out(24'h000000);
      compare_out($sformatf("mr_after%0d", k));
      check_ready($sformatf("mr_ready%0d", k), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
